// File: rtl/booth_mac_acc.sv
// booth_mac_acc: sequential signed multiply-accumulate controller that feeds
// an external combinational 8x8 Booth multiplier and saturates a dot product.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, len            job launch and pair count (sampled in IDLE)
//   in_valid/in_ready     operand pair handshake, in_a/in_b signed 8-bit
//   mul_a/mul_b, mul_p    registered operands out, combinational product in
//   out_valid/out_ready   result handshake, out_acc result, out_sat sticky flag
//   busy                  high whenever a job is in progress or pending output
module booth_mac_acc #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_MUL,
        S_DONE
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [7:0]       mul_a_q, mul_a_d;
    logic [7:0]       mul_b_q, mul_b_d;

    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum;
    logic             pos_ovf;
    logic             neg_ovf;
    logic [ACC_W-1:0] sum_sat;

    // One extra guard bit: the top two bits disagree exactly on overflow.
    always_comb begin
        prod_ext = {{(ACC_W-15){mul_p[15]}}, mul_p};
        sum      = {acc_q[ACC_W-1], acc_q} + prod_ext;
        pos_ovf  = ~sum[ACC_W] & sum[ACC_W-1];
        neg_ovf  = sum[ACC_W] & ~sum[ACC_W-1];
        sum_sat  = sum[ACC_W-1:0];
        if (pos_ovf) begin
            sum_sat = ACC_MAX;
        end else if (neg_ovf) begin
            sum_sat = ACC_MIN;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = len;
                    acc_d = '0;
                    sat_d = 1'b0;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    mul_a_d = in_a;
                    mul_b_d = in_b;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = sum_sat;
                sat_d = sat_q | pos_ovf | neg_ovf;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_acc   = acc_q;
    assign out_sat   = sat_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule
